sram_arb2: RTL and testbench
============================

// Module: sram_arb2
// PURPOSE
//  Arbitrates one shared dual-bank 32-bit SRAM array between two requesters:
//  m0 is the AHB bridge port and is latency critical; m1 is the DMA/secondary port.
//  After reset, an init FSM zero-fills both banks before either port is granted.
//  Drives the bank chip-enables, write enable, address and data of the SRAM macros.
//  Returns read data to the requester that issued the read.
// PARAMETERS
//  ADDR_W        13  word-address width per bank; each bank holds 2^ADDR_W words
//  STARVE_LIMIT  4   number of consecutive lost cycles for m1 before m1 is forced a grant; must be >=1
//  INIT_EN       1   1: zero-fill both banks after reset; 0: skip init and start in RUN
// PORTS
//  hclk        in   1       clock; also drives sram_clk
//  hreset      in   1       asynchronous reset, active low
//  mN_req      in   1       N=0,1; request an access; held with stable fields until granted
//  mN_we       in   1       1 = write, 0 = read
//  mN_bank     in   1       bank select (0 = bank0, 1 = bank1)
//  mN_addr     in   ADDR_W  word address
//  mN_be       in   4       byte enables; [0] = bits 7:0
//  mN_wdata    in   32      write data, already lane-replicated by the requester
//  mN_gnt      out  1       access issued this cycle
//  mN_rvalid   out  1       read data valid, one cycle after a granted read
//  mN_rdata    out  32      read data; holds the last read value
//  sram_clk    out  1       equal to hclk
//  bank0_cen   out  4       bank0 per-byte chip enable, active low
//  bank1_cen   out  4       bank1 per-byte chip enable, active low
//  sram_w_en   out  1       write enable, active low
//  sram_addr   out  ADDR_W  SRAM word address
//  sram_data   out  32      SRAM write data
//  sram_q_b0   in   32      bank0 read data {q3,q2,q1,q0}
//  sram_q_b1   in   32      bank1 read data {q7,q6,q5,q4}
//  init_done   out  1       1 once zero-fill is complete
// BEHAVIOUR
//  Reset values (hold for as long as hreset is low):
//   - mN_gnt = 0, mN_rvalid = 0, mN_rdata = 0.
//   - bankX_cen = 4'b1111, sram_w_en = 1, sram_addr = 0, sram_data = 0.
//   - init_done = !INIT_EN; starve_cnt = 0; init_cnt = 0.
//   - state = INIT if INIT_EN = 1, else RUN.
//  State INIT:
//   - Each cycle, write zero to both banks at address init_cnt:
//     bank0_cen = bank1_cen = 0000, sram_w_en = 0, sram_data = 0.
//   - Both gnt = 0; requests stall.
//   - At init_cnt == 2^ADDR_W-1, the next state is RUN.
//   - Init takes exactly 2^ADDR_W cycles; init_done = 1 from the first RUN cycle.
//  State RUN (terminal until reset), arbitration is combinational:
//   - force1 = (starve_cnt == STARVE_LIMIT)
//   - m0_gnt = m0_req & ~(force1 & m1_req)
//   - m1_gnt = m1_req & (~m0_req | force1)
//   - At most one gnt is high in any cycle.
//  starve_cnt:
//   - Increments (saturating at STARVE_LIMIT) when m1_req & ~m1_gnt.
//   - Clears to 0 when m1_gnt = 1 or m1_req = 0.
//  Granted cycle drives the SRAM from the winner's fields:
//   - Selected bank cen = ~be; other bank cen = 1111.
//   - sram_w_en = ~we; sram_addr = addr.
//   - sram_data = wdata on writes, 0 on reads.
//   - be = 0000 gives a harmless no-op access.
//  No grant: both cen = 1111, sram_w_en = 1, sram_addr = 0, sram_data = 0.
//  Read of port N granted in cycle T:
//   - Port and bank are registered at that edge.
//   - In cycle T+1: mN_rvalid = 1 and mN_rdata = sram_q_b<bank> (combinational pass-through).
//   - The value is captured into a hold register at the end of T+1.
//   - Outside rvalid, mN_rdata = hold value.
//   - The other port's rdata is untouched.
//  Write grant: single cycle, no response; mN_rvalid stays 0.
//  Back-to-back grants (any mix of ports, banks, read/write) are allowed every cycle.
//  A write at T followed by a read of the same address at T+1 returns the new data (macro write-through not required).
//  Async reset mid-operation:
//   - Outputs go to reset values immediately.
//   - In-flight rvalid is dropped.
//   - init restarts from address 0.
// TESTING
//  1. INIT_EN=1, ADDR_W=4; release reset with m0_req held (read bank0 addr 3):
//     - 16 zero-writes to addr 0..15 with cen 0000/0000 and w_en 0.
//     - init_done rises at cycle 16, and m0_gnt rises in the same cycle.
//  2. Both ports request reads continuously, STARVE_LIMIT=4:
//     - Grant sequence is m0,m0,m0,m0,m1, repeating.
//     - No cycle has both gnt high.
//  3. m1 writes bank1 addr 5 with be 0010 and wdata 0x0000AB00:
//     - bank1_cen = 1101, bank0_cen = 1111, w_en = 0, sram_addr = 5.
//     - A subsequent m1 read of addr 5 gives m1_rvalid in T+1 with byte1 = 0xAB.
//  4. m0 reads bank0 at cycle T and m1 reads bank1 at T+1:
//     - m0_rvalid at T+1 with the bank0 value; m1_rvalid at T+2 with the bank1 value.
//     - Both rdata values hold afterwards.
//  5. Assert hreset during INIT at init_cnt = 7:
//     - cen = 1111 and init_done = 0 immediately.
//     - After release, writes restart at address 0.
//  6. m1_req alone with m0 idle:
//     - m1_gnt in the same cycle.
//     - starve_cnt stays 0.

Source files
------------

// File: rtl/sram_arb2.sv
// sram_arb2: two-port arbiter in front of a shared dual-bank 32-bit SRAM.
// m0 (AHB bridge) wins by default; m1 (DMA) is forced through after
// STARVE_LIMIT consecutive lost cycles. After reset an init phase zero-fills
// both banks before any grant is issued. Read data returns one cycle after
// the grant and is then held per port.
module sram_arb2 #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 4,
  parameter bit INIT_EN      = 1'b1
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_bank,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_be,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_bank,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              sram_clk,
  output logic [3:0]        bank0_cen,
  output logic [3:0]        bank1_cen,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data,
  input  logic [31:0]       sram_q_b0,
  input  logic [31:0]       sram_q_b1,
  output logic              init_done
);

  localparam int                SC_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]   SC_MAX    = SC_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] INIT_LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t S_RST = INIT_EN ? S_INIT : S_RUN;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              run;
  logic              force1;

  // Read-return stage: registered at the grant edge, consumed one cycle later
  logic              rd_vld_p1;
  logic              rd_port_p1;
  logic              rd_bank_p1;
  logic [31:0]       hold0_p1;
  logic [31:0]       hold1_p1;
  logic [31:0]       q_sel;

  assign sram_clk  = hclk;
  assign init_done = (state == S_RUN);

  // FSM state register; init restarts from scratch on every reset
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) state <= S_RST;
    else         state <= state_nxt;
  end

  // Leave INIT after the last word of the bank has been written
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == INIT_LAST) state_nxt = S_RUN;
  end

  // Zero-fill address counter, only advances during INIT
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset)               init_cnt <= '0;
    else if (state == S_INIT)  init_cnt <= init_cnt + ADDR_W'(1);
  end

  // Arbitration is purely combinational; the reset term keeps grants low while
  // hreset is asserted even though the requests may still be high.
  assign run    = hreset & (state == S_RUN);
  assign force1 = (starve_cnt == SC_MAX);
  assign m0_gnt = run & m0_req & ~(force1 & m1_req);
  assign m1_gnt = run & m1_req & (~m0_req | force1);

  // Count consecutive cycles m1 asks and loses; any win or idle cycle clears it
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      starve_cnt <= '0;
    end else if (state == S_RUN) begin
      if (m1_req & ~m1_gnt) begin
        if (starve_cnt != SC_MAX) starve_cnt <= starve_cnt + SC_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // SRAM drive: zero-fill in INIT, winner's fields in RUN, idle otherwise
  always_comb begin
    bank0_cen = 4'b1111;
    bank1_cen = 4'b1111;
    sram_w_en = 1'b1;
    sram_addr = '0;
    sram_data = '0;
    if (hreset) begin
      if (state == S_INIT) begin
        bank0_cen = 4'b0000;
        bank1_cen = 4'b0000;
        sram_w_en = 1'b0;
        sram_addr = init_cnt;
      end else if (m0_gnt) begin
        if (m0_bank) bank1_cen = ~m0_be;
        else         bank0_cen = ~m0_be;
        sram_w_en = ~m0_we;
        sram_addr = m0_addr;
        sram_data = m0_we ? m0_wdata : 32'h0;
      end else if (m1_gnt) begin
        if (m1_bank) bank1_cen = ~m1_be;
        else         bank0_cen = ~m1_be;
        sram_w_en = ~m1_we;
        sram_addr = m1_addr;
        sram_data = m1_we ? m1_wdata : 32'h0;
      end
    end
  end

  // Grant edge -> return cycle: remember who read and from which bank
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      rd_vld_p1  <= 1'b0;
      rd_port_p1 <= 1'b0;
      rd_bank_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
      rd_port_p1 <= m1_gnt;
      rd_bank_p1 <= m1_gnt ? m1_bank : m0_bank;
    end
  end

  assign q_sel     = rd_bank_p1 ? sram_q_b1 : sram_q_b0;
  assign m0_rvalid = rd_vld_p1 & ~rd_port_p1;
  assign m1_rvalid = rd_vld_p1 &  rd_port_p1;
  assign m0_rdata  = m0_rvalid ? q_sel : hold0_p1;
  assign m1_rdata  = m1_rvalid ? q_sel : hold1_p1;

  // Per-port hold registers capture the returned word at the end of rvalid
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      hold0_p1 <= '0;
      hold1_p1 <= '0;
    end else begin
      if (m0_rvalid) hold0_p1 <= q_sel;
      if (m1_rvalid) hold1_p1 <= q_sel;
    end
  end

endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: randomized and directed bench for sram_arb2 with a
// behavioural SRAM macro and a transaction-level reference model.
module tb_sram_arb2;

  localparam int AW    = 4;
  localparam int LIM   = 4;
  localparam int DEPTH = 1 << AW;

  logic          hclk = 1'b0;
  logic          hreset = 1'b0;
  logic          m0_req = 0, m0_we = 0, m0_bank = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [3:0]    m0_be = '0;
  logic [31:0]   m0_wdata = '0;
  logic          m1_req = 0, m1_we = 0, m1_bank = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [3:0]    m1_be = '0;
  logic [31:0]   m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          sram_clk, sram_w_en, init_done;
  logic [3:0]    bank0_cen, bank1_cen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_data, sram_q_b0, sram_q_b1;

  always #5 hclk = ~hclk;

  sram_arb2 #(.ADDR_W(AW), .STARVE_LIMIT(LIM), .INIT_EN(1'b1)) dut (
    .hclk(hclk), .hreset(hreset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_bank(m0_bank), .m0_addr(m0_addr),
    .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_bank(m1_bank), .m1_addr(m1_addr),
    .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .sram_clk(sram_clk), .bank0_cen(bank0_cen), .bank1_cen(bank1_cen),
    .sram_w_en(sram_w_en), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_q_b0(sram_q_b0), .sram_q_b1(sram_q_b1), .init_done(init_done)
  );

  // Synchronous byte-enabled SRAM macros, filled with garbage before init
  logic [31:0] mac0 [DEPTH];
  logic [31:0] mac1 [DEPTH];
  logic [31:0] q0, q1;
  assign sram_q_b0 = q0;
  assign sram_q_b1 = q1;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mac0[i] <= $urandom;
      mac1[i] <= $urandom;
    end
  end

  always @(posedge sram_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!bank0_cen[b]) begin
        if (!sram_w_en) mac0[sram_addr][b*8 +: 8] <= sram_data[b*8 +: 8];
        else            q0[b*8 +: 8] <= mac0[sram_addr][b*8 +: 8];
      end
      if (!bank1_cen[b]) begin
        if (!sram_w_en) mac1[sram_addr][b*8 +: 8] <= sram_data[b*8 +: 8];
        else            q1[b*8 +: 8] <= mac1[sram_addr][b*8 +: 8];
      end
    end
  end

  // Reference model state
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ref0 [DEPTH];
  logic [31:0] ref1 [DEPTH];
  int          init_left;
  bit          lost_q [$];
  bit          pend_v;
  bit          pend_port;
  logic [31:0] pend_data;
  logic [31:0] hold0, hold1;
  bit          e_g0, e_g1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_left = DEPTH;
    lost_q.delete();
    pend_v = 0;
    hold0 = '0;
    hold1 = '0;
    e_g0 = 0;
    e_g1 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ref0[i] = '0;
      ref1[i] = '0;
    end
  endtask

  // One clock cycle: inputs are already applied (just after a falling edge).
  // Compare everything against the model, then advance the model at the edge.
  task automatic step();
    bit            force1, bk, we;
    logic [3:0]    ec0, ec1, be;
    logic          ewe, edone, erv0, erv1;
    logic [AW-1:0] ea;
    logic [31:0]   ed, wd, erd0, erd1, cur;
    #1;
    ec0 = 4'hF; ec1 = 4'hF; ewe = 1'b1; ea = '0; ed = '0;
    e_g0 = 0; e_g1 = 0;
    bk = 0; we = 0; be = '0; wd = '0;
    if (init_left > 0) begin
      ec0 = 4'h0; ec1 = 4'h0; ewe = 1'b0; ea = AW'(DEPTH - init_left); edone = 1'b0;
    end else begin
      edone = 1'b1;
      force1 = (lost_q.size() == LIM);
      foreach (lost_q[i]) force1 &= lost_q[i];
      e_g1 = m1_req && (!m0_req || force1);
      e_g0 = m0_req && !e_g1;
      if (e_g0 || e_g1) begin
        bk = e_g1 ? m1_bank  : m0_bank;
        we = e_g1 ? m1_we    : m0_we;
        be = e_g1 ? m1_be    : m0_be;
        wd = e_g1 ? m1_wdata : m0_wdata;
        ea = e_g1 ? m1_addr  : m0_addr;
        if (bk) ec1 = ~be; else ec0 = ~be;
        ewe = ~we;
        ed  = we ? wd : 32'h0;
      end
    end
    erv0 = pend_v && !pend_port;
    erv1 = pend_v &&  pend_port;
    erd0 = erv0 ? pend_data : hold0;
    erd1 = erv1 ? pend_data : hold1;
    check("m0_gnt", m0_gnt, e_g0);
    check("m1_gnt", m1_gnt, e_g1);
    check("bank0_cen", bank0_cen, ec0);
    check("bank1_cen", bank1_cen, ec1);
    check("sram_w_en", sram_w_en, ewe);
    check("sram_addr", sram_addr, ea);
    check("sram_data", sram_data, ed);
    check("init_done", init_done, edone);
    check("m0_rvalid", m0_rvalid, erv0);
    check("m1_rvalid", m1_rvalid, erv1);
    check("m0_rdata", m0_rdata, erd0);
    check("m1_rdata", m1_rdata, erd1);
    @(posedge hclk);
    if (pend_v) begin
      if (pend_port) hold1 = pend_data; else hold0 = pend_data;
    end
    pend_v = 0;
    if (init_left > 0) begin
      init_left--;
    end else begin
      if (e_g0 || e_g1) begin
        cur = bk ? ref1[ea] : ref0[ea];
        if (!we) begin
          pend_v = 1; pend_port = e_g1; pend_data = cur;
        end else begin
          for (int b = 0; b < 4; b++) if (be[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
          if (bk) ref1[ea] = cur; else ref0[ea] = cur;
        end
      end
      lost_q.push_back(m1_req && !e_g1);
      if (lost_q.size() > LIM) void'(lost_q.pop_front());
    end
    @(negedge hclk);
  endtask

  task automatic set_m0(input logic r, input logic w, input logic b, input int a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_bank = b; m0_addr = AW'(a); m0_be = be; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic b, input int a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_bank = b; m1_addr = AW'(a); m1_be = be; m1_wdata = d;
  endtask

  // New random request unless the previous one is still waiting for a grant
  task automatic drive_rand();
    logic w;
    if (!(m0_req && !e_g0)) begin
      w = 1'($urandom_range(0, 1));
      set_m0(($urandom_range(0, 99) < 55), w, 1'($urandom_range(0, 1)),
             $urandom_range(0, DEPTH - 1), w ? 4'($urandom_range(0, 15)) : 4'hF, $urandom);
    end
    if (!(m1_req && !e_g1)) begin
      w = 1'($urandom_range(0, 1));
      set_m1(($urandom_range(0, 99) < 60), w, 1'($urandom_range(0, 1)),
             $urandom_range(0, DEPTH - 1), w ? 4'($urandom_range(0, 15)) : 4'hF, $urandom);
    end
  endtask

  logic [9:0] seq;
  int         n_init;

  initial begin
    // Reset held: requests high must not produce grants
    set_m0(1, 0, 0, 3, 4'hF, 32'h0);
    set_m1(1, 0, 1, 2, 4'hF, 32'h0);
    repeat (3) @(negedge hclk);
    #1;
    check("rst_m0_gnt", m0_gnt, 1'b0);
    check("rst_m1_gnt", m1_gnt, 1'b0);
    check("rst_bank0_cen", bank0_cen, 4'hF);
    check("rst_bank1_cen", bank1_cen, 4'hF);
    check("rst_w_en", sram_w_en, 1'b1);
    check("rst_addr", sram_addr, '0);
    check("rst_data", sram_data, '0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);

    // Reset in the middle of init, at init_cnt = 7
    set_m0(0, 0, 0, 0, 4'h0, 32'h0);
    set_m1(0, 0, 0, 0, 4'h0, 32'h0);
    @(negedge hclk);
    hreset = 1'b1;
    repeat (7) @(negedge hclk);
    #1;
    check("init_addr7", sram_addr, 32'd7);
    check("init_cen7", {bank0_cen, bank1_cen}, 8'h00);
    hreset = 1'b0;
    #1;
    check("midrst_cen", {bank0_cen, bank1_cen}, 8'hFF);
    check("midrst_w_en", sram_w_en, 1'b1);
    check("midrst_init_done", init_done, 1'b0);
    @(negedge hclk);
    hreset = 1'b1;
    #1;
    check("restart_addr0", sram_addr, 32'd0);
    check("restart_cen", {bank0_cen, bank1_cen}, 8'h00);

    // Full init with m0 read held: grant must coincide with init_done
    model_reset();
    set_m0(1, 0, 0, 3, 4'hF, 32'h0);
    n_init = -1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (init_done === 1'b1) begin
        n_init = n;
        break;
      end
      step();
    end
    check("init_cycles", n_init, 16);
    check("first_run_m0_gnt", m0_gnt, 1'b1);
    step();
    m0_req = 0;

    // m1 partial-byte write then read-back
    set_m1(1, 1, 1, 5, 4'b0010, 32'h0000AB00);
    #1;
    check("wr_bank1_cen", bank1_cen, 4'b1101);
    check("wr_bank0_cen", bank0_cen, 4'b1111);
    check("wr_w_en", sram_w_en, 1'b0);
    check("wr_addr", sram_addr, 32'd5);
    step();
    set_m1(1, 0, 1, 5, 4'hF, 32'h0);
    step();
    m1_req = 0;
    check("rb_m1_rvalid", m1_rvalid, 1'b1);
    check("rb_m1_rdata", m1_rdata, 32'h0000AB00);
    step();

    // Back-to-back reads from both ports and both banks
    set_m0(1, 1, 0, 3, 4'hF, 32'h11223344);
    step();
    m0_req = 0;
    set_m1(1, 1, 1, 9, 4'hF, 32'hCAFEF00D);
    step();
    m1_req = 0;
    set_m0(1, 0, 0, 3, 4'hF, 32'h0);
    step();
    m0_req = 0;
    set_m1(1, 0, 1, 9, 4'hF, 32'h0);
    check("b2b_m0_rvalid", m0_rvalid, 1'b1);
    check("b2b_m0_rdata", m0_rdata, 32'h11223344);
    step();
    m1_req = 0;
    check("b2b_m1_rvalid", m1_rvalid, 1'b1);
    check("b2b_m1_rdata", m1_rdata, 32'hCAFEF00D);
    check("b2b_m0_hold", m0_rdata, 32'h11223344);
    check("b2b_m0_rvalid_off", m0_rvalid, 1'b0);
    step();
    check("b2b_m1_hold", m1_rdata, 32'hCAFEF00D);
    check("b2b_m1_rvalid_off", m1_rvalid, 1'b0);

    // m1 alone is granted immediately
    set_m1(1, 0, 0, 1, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("m1_alone_gnt", m1_gnt, 1'b1);
      step();
    end
    m1_req = 0;
    step();

    // Continuous contention: m0 x4 then forced m1
    set_m0(1, 0, 0, 2, 4'hF, 32'h0);
    set_m1(1, 0, 1, 4, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      seq[i] = m1_gnt;
      step();
    end
    check("starve_seq", {22'h0, seq}, 32'b1000010000);
    set_m0(0, 0, 0, 0, 4'h0, 32'h0);
    set_m1(0, 0, 0, 0, 4'h0, 32'h0);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step();
    end

    // Async reset with a read in flight
    set_m1(0, 0, 0, 0, 4'h0, 32'h0);
    set_m0(1, 0, 0, 3, 4'hF, 32'h0);
    step();
    check("inflight_rvalid", m0_rvalid, 1'b1);
    hreset = 1'b0;
    #1;
    check("async_rvalid_drop", {m0_rvalid, m1_rvalid}, 2'b00);
    check("async_rdata", m0_rdata | m1_rdata, 32'h0);
    check("async_gnt", {m0_gnt, m1_gnt}, 2'b00);
    check("async_cen", {bank0_cen, bank1_cen}, 8'hFF);
    check("async_init_done", init_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
